vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between two requesters: VGA scan-out prefetch (real-time) and a CPU load/store port.
- Prefetches pixels in raster order into a small FIFO; the FIFO feeds the `pixel` input of the VGA generator.
- Sits between the framebuffer RAM, the VGA pixel path and the CPU bus, and schedules every RAM access.

---
 rtl/vga_fb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA
// scan-out prefetcher and a CPU load/store port. Video reads are issued in
// raster order into a small FIFO that feeds the VGA pixel path. The CPU is
// served whenever the FIFO holds enough margin.
module vga_fb_arbiter #(
    parameter int RES_X      = 640,
    parameter int RES_Y      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [31:0]       pixel,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Occupancy counts FIFO entries plus the one possible in-flight read,
    // so it needs one bit more than the pointer difference.
    localparam int OCC_W = PTR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RES_X * RES_Y - 1);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  LOW_OCC   = OCC_W'(LOW_WM);

    typedef enum logic [1:0] {
        S_WAIT_FRAME,
        S_FETCH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              vid_tag_q, vid_tag_d;
    logic              underflow_q, underflow_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_rd_pend_q, cpu_rd_pend_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];

    logic [PTR_W:0]    level;
    logic [OCC_W-1:0]  occ;
    logic              fifo_empty;
    logic              vid_elig;
    logic              vid_urgent;
    logic              cpu_ok;
    logic              grant_vid;
    logic              grant_cpu;
    logic              do_push;
    logic              do_pop;

    // Arbitration: one grant per cycle. Video wins outright near starvation,
    // otherwise a waiting CPU request goes first, then video fills the FIFO.
    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        occ        = OCC_W'(level) + OCC_W'(vid_tag_q);
        fifo_empty = (level == '0);
        // frame_start cancels the video grant of its own cycle; the restart
        // fetch from address 0 begins on the following cycle.
        vid_elig   = !rst && (state_q == S_FETCH) && (occ < DEPTH_OCC) && !frame_start;
        vid_urgent = vid_elig && (occ <= LOW_OCC);
        // The ack cycle is never re-granted, so a held request is served once.
        cpu_ok     = !rst && cpu_req && !cpu_pend_q;
        grant_cpu  = cpu_ok && !vid_urgent;
        grant_vid  = vid_elig && !grant_cpu;
        do_push    = vid_tag_q && !frame_start;
        do_pop     = pix_pop && !fifo_empty && !frame_start;
    end

    // RAM port drive, purely combinational from the grant.
    always_comb begin
        mem_en    = grant_vid || grant_cpu;
        mem_we    = grant_cpu && cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_vid) begin
            mem_addr  = fetch_addr_q;
        end
    end

    // Prefetch FSM next state, fetch address, FIFO pointers and underflow flag.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        vid_tag_d    = grant_vid;
        underflow_d  = underflow_q;
        if (frame_start) begin
            // Restart the frame: flush the FIFO and orphan any video read
            // whose data is still on its way back.
            state_d      = S_FETCH;
            fetch_addr_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            vid_tag_d    = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            if (grant_vid) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                if (fetch_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
            end
            if (pix_pop && fifo_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // CPU completion tracking: ack follows the grant by one cycle, read data
    // is captured from the RAM during the ack cycle and held afterwards.
    always_comb begin
        cpu_pend_d    = grant_cpu;
        cpu_rd_pend_d = grant_cpu && !cpu_we;
        cpu_rdata_d   = cpu_rdata_q;
        if (cpu_rd_pend_q) begin
            cpu_rdata_d = mem_rdata;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_WAIT_FRAME;
            fetch_addr_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            vid_tag_q     <= 1'b0;
            underflow_q   <= 1'b0;
            cpu_pend_q    <= 1'b0;
            cpu_rd_pend_q <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            vid_tag_q     <= vid_tag_d;
            underflow_q   <= underflow_d;
            cpu_pend_q    <= cpu_pend_d;
            cpu_rd_pend_q <= cpu_rd_pend_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

    // FIFO storage; occupancy is governed by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= mem_rdata;
        end
    end

    // Pixel path and CPU outputs.
    always_comb begin
        pix_valid = !fifo_empty;
        pixel     = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        underflow = underflow_q;
        cpu_ack   = cpu_pend_q;
        cpu_rdata = cpu_rd_pend_q ? mem_rdata : cpu_rdata_q;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: a behavioural RAM, a queue-based reference
// model of the prefetch/arbitration rules, and one task per scenario.
module tb_vga_fb_arbiter;

    localparam int RES_X  = 640;
    localparam int RES_Y  = 4;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int LOW_WM = 2;
    localparam int NWORDS = RES_X * RES_Y;
    localparam int MEMW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_pop = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       pixel;
    logic              pix_valid;
    logic              underflow;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .RES_X(RES_X), .RES_Y(RES_Y), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(DEPTH), .LOW_WM(LOW_WM)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_pop(pix_pop),
        .pixel(pixel), .pix_valid(pix_valid), .underflow(underflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Framebuffer RAM: single port, synchronous read with one cycle latency.
    logic [31:0] ram [MEMW];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model state
    int          m_state;          // 0 waiting for frame, 1 fetching, 2 frame fully fetched
    logic [31:0] m_fifo[$];
    bit          m_infl;
    logic [31:0] m_infl_data;
    int          m_fetch;
    bit          m_under;
    bit          m_ack_pend;
    bit          m_ack_rd;
    logic [31:0] m_ack_data;
    logic [31:0] m_rdata;
    logic [31:0] m_mem [MEMW];

    // Expected outputs for the current cycle
    bit                e_gv, e_gc;
    logic              e_mem_en, e_mem_we, e_pix_valid, e_under, e_ack;
    logic [ADDR_W-1:0] e_mem_addr;
    logic [31:0]       e_mem_wdata, e_pixel, e_cpu_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_state = 0; m_fifo.delete(); m_infl = 0; m_fetch = 0; m_under = 0;
        m_ack_pend = 0; m_ack_rd = 0; m_rdata = '0; m_ack_data = '0;
    endtask

    task automatic model_eval();
        int occ;
        bit elig, urgent, cpu_ok;
        occ    = m_fifo.size() + int'(m_infl);
        elig   = !rst && m_state == 1 && occ < DEPTH && !frame_start;
        urgent = elig && occ <= LOW_WM;
        cpu_ok = !rst && cpu_req && !m_ack_pend;
        e_gc   = cpu_ok && !urgent;
        e_gv   = elig && (urgent || !cpu_ok);
        e_mem_en    = e_gv || e_gc;
        e_mem_we    = e_gc && cpu_we;
        e_mem_addr  = e_gc ? cpu_addr : (e_gv ? ADDR_W'(m_fetch) : '0);
        e_mem_wdata = e_gc ? cpu_wdata : '0;
        e_pix_valid = m_fifo.size() != 0;
        e_pixel     = (m_fifo.size() != 0) ? m_fifo[0] : '0;
        e_under     = m_under;
        e_ack       = m_ack_pend;
        e_cpu_rdata = (m_ack_pend && m_ack_rd) ? m_ack_data : m_rdata;
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_ack_pend && m_ack_rd) m_rdata = m_ack_data;
        m_ack_pend = e_gc;
        m_ack_rd   = e_gc && !cpu_we;
        if (e_gc) begin
            if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
            else        m_ack_data = m_mem[cpu_addr];
        end
        if (frame_start) begin
            m_fifo.delete(); m_infl = 0; m_fetch = 0; m_under = 0; m_state = 1;
        end else begin
            if (pix_pop) begin
                if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                else m_under = 1;
            end
            if (m_infl) m_fifo.push_back(m_infl_data);
            if (m_fifo.size() > DEPTH) begin
                $display("FAIL fifo_overflow: level %0d exceeds depth %0d", m_fifo.size(), DEPTH);
                n_err++;
            end
            m_infl = e_gv;
            if (e_gv) begin
                m_infl_data = m_mem[m_fetch];
                if (m_fetch == NWORDS - 1) m_state = 2;
                m_fetch++;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        bit was_ack;
        was_ack = e_ack;
        @(posedge clk);
        model_commit();
        @(negedge clk);
        frame_start = 1'b0;
        if (was_ack) cpu_req = 1'b0;
    endtask

    task automatic drain_cpu();
        for (int k = 0; k < 6 && cpu_req; k++) begin
            settle();
            advance();
        end
    endtask

    task automatic rand_cpu(input int pct);
        if (!cpu_req && ($urandom % 100) < pct) begin
            cpu_req   = 1'b1;
            cpu_we    = $urandom % 2;
            cpu_addr  = ADDR_W'($urandom_range(0, MEMW - 1));
            cpu_wdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3; pix_pop = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if ({mem_en, mem_we, mem_addr, mem_wdata, pixel, pix_valid, underflow, cpu_ack, cpu_rdata} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h pix=%h v=%b uf=%b ack=%b rd=%h want all 0",
                         mem_en, mem_we, mem_addr, mem_wdata, pixel, pix_valid, underflow, cpu_ack, cpu_rdata);
            end
            advance();
        end
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; pix_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++;
            if (mem_en !== e_mem_en || mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL wait_frame_idle: got mem_en=%b want 0", mem_en);
            end
            advance();
        end
    endtask

    task automatic test_underflow_pre_frame();
        for (int i = 0; i < 3; i++) begin
            pix_pop = 1'b1;
            settle();
            n_vec++;
            if (pixel !== 32'h0 || pix_valid !== 1'b0) begin
                n_err++;
                $display("FAIL empty_pixel: got pixel=%h valid=%b want 0/0", pixel, pix_valid);
            end
            advance();
        end
        pix_pop = 1'b0;
        settle();
        n_vec++;
        if (underflow !== 1'b1 || underflow !== e_under) begin
            n_err++;
            $display("FAIL underflow_set: got %b want 1", underflow);
        end
        frame_start = 1'b1;
        settle();
        advance();
        settle();
        n_vec++;
        if (underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: got %b want 0", underflow);
        end
        advance();
    endtask

    task automatic test_prefill();
        frame_start = 1'b1; pix_pop = 1'b0;
        settle();
        advance();
        for (int i = 0; i < 8; i++) begin
            settle();
            n_vec++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(i)) begin
                n_err++;
                $display("FAIL prefill_addr%0d: got en=%b we=%b addr=%0d want 1/0/%0d", i, mem_en, mem_we, mem_addr, i);
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if (mem_en !== 1'b0 || pix_valid !== 1'b1 || pixel !== ram[0] || pixel !== e_pixel) begin
                n_err++;
                $display("FAIL prefill_stall: got en=%b valid=%b pixel=%h want 0/1/%h", mem_en, pix_valid, pixel, e_pixel);
            end
            advance();
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < RES_X; i++) begin
            pix_pop = 1'b1;
            settle();
            n_vec++;
            if (pix_valid !== 1'b1 || pixel !== 32'(i) || pixel !== e_pixel || underflow !== 1'b0) begin
                n_err++;
                $display("FAIL stream_px%0d: got valid=%b pixel=%0d uf=%b want 1/%0d/0", i, pix_valid, pixel, underflow, i);
            end
            advance();
        end
        pix_pop = 1'b0;
    endtask

    task automatic test_done();
        frame_start = 1'b1; pix_pop = 1'b0;
        settle();
        advance();
        for (int i = 0; i < 10; i++) begin settle(); advance(); end
        for (int i = 0; i < NWORDS; i++) begin
            pix_pop = 1'b1;
            settle();
            n_vec++;
            if (pix_valid !== 1'b1 || pixel !== 32'(i) || mem_en !== e_mem_en || mem_addr !== e_mem_addr) begin
                n_err++;
                $display("FAIL frame_px%0d: got valid=%b pixel=%0d en=%b addr=%0d want 1/%0d/%b/%0d",
                         i, pix_valid, pixel, mem_en, mem_addr, i, e_mem_en, e_mem_addr);
            end
            advance();
        end
        pix_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if (mem_en !== 1'b0 || pix_valid !== 1'b0 || underflow !== 1'b0) begin
                n_err++;
                $display("FAIL done_idle: got en=%b valid=%b uf=%b want 0/0/0", mem_en, pix_valid, underflow);
            end
            advance();
        end
        pix_pop = 1'b1;
        settle();
        advance();
        pix_pop = 1'b0;
        settle();
        n_vec++;
        if (underflow !== 1'b1 || pixel !== 32'h0) begin
            n_err++;
            $display("FAIL done_underflow: got uf=%b pixel=%h want 1/0", underflow, pixel);
        end
        advance();
    endtask

    task automatic test_frame_restart();
        frame_start = 1'b1;
        settle();
        advance();
        for (int i = 0; i < 10; i++) begin settle(); advance(); end
        for (int k = 0; k < 300 && m_fetch != 100; k++) begin
            pix_pop = 1'b1;
            settle();
            advance();
        end
        n_vec++;
        if (m_fetch != 100 || !m_infl) begin
            n_err++;
            $display("FAIL restart_setup: got fetch=%0d inflight=%0d want 100/1", m_fetch, m_infl);
        end
        frame_start = 1'b1; pix_pop = 1'b1;
        settle();
        n_vec++;
        if (mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL restart_grant_blocked: got mem_en=%b want 0", mem_en);
        end
        advance();
        pix_pop = 1'b0;
        settle();
        n_vec++;
        if (pix_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL restart_first: got valid=%b en=%b addr=%0d want 0/1/0", pix_valid, mem_en, mem_addr);
        end
        advance();
        settle();
        n_vec++;
        if (pix_valid !== 1'b0 || pixel !== 32'h0) begin
            n_err++;
            $display("FAIL restart_stale_dropped: got valid=%b pixel=%h want 0/0", pix_valid, pixel);
        end
        advance();
        settle();
        n_vec++;
        if (pix_valid !== 1'b1 || pixel !== ram[0] || pixel !== e_pixel) begin
            n_err++;
            $display("FAIL restart_head: got valid=%b pixel=%h want 1/%h", pix_valid, pixel, e_pixel);
        end
        advance();
    endtask

    task automatic test_cpu_full();
        pix_pop = 1'b0;
        for (int i = 0; i < 12; i++) begin settle(); advance(); end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
        settle();
        n_vec++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, ADDR_W'(5), 32'hDEADBEEF} || cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_wr_grant: got en=%b we=%b addr=%0d wd=%h ack=%b want 1/1/5/deadbeef/0",
                     mem_en, mem_we, mem_addr, mem_wdata, cpu_ack);
        end
        advance();
        settle();
        n_vec++;
        if (cpu_ack !== 1'b1 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_wr_ack: got ack=%b en=%b want 1/0", cpu_ack, mem_en);
        end
        advance();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = '0;
        settle();
        n_vec++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(5) || cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_rd_grant: got en=%b we=%b addr=%0d ack=%b want 1/0/5/0", mem_en, mem_we, mem_addr, cpu_ack);
        end
        advance();
        settle();
        n_vec++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL cpu_rd_ack: got ack=%b rdata=%h want 1/deadbeef", cpu_ack, cpu_rdata);
        end
        advance();
        settle();
        n_vec++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL cpu_rd_hold: got ack=%b rdata=%h want 0/deadbeef", cpu_ack, cpu_rdata);
        end
        advance();
    endtask

    task automatic test_contention();
        frame_start = 1'b1; pix_pop = 1'b0;
        settle();
        advance();
        for (int i = 0; i < 10; i++) begin settle(); advance(); end
        for (int i = 0; i < 300; i++) begin
            pix_pop = 1'b1;
            rand_cpu(80);
            settle();
            n_vec++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata}) begin
                n_err++;
                $display("FAIL cont_mem%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i, mem_en, mem_we, mem_addr, mem_wdata,
                         e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata);
            end
            n_vec++;
            if ({pix_valid, pixel, underflow} !== {e_pix_valid, e_pixel, 1'b0}) begin
                n_err++;
                $display("FAIL cont_pix%0d: got v=%b px=%h uf=%b want %b/%h/0", i, pix_valid, pixel, underflow, e_pix_valid, e_pixel);
            end
            n_vec++;
            if ({cpu_ack, cpu_rdata} !== {e_ack, e_cpu_rdata}) begin
                n_err++;
                $display("FAIL cont_cpu%0d: got ack=%b rd=%h want %b/%h", i, cpu_ack, cpu_rdata, e_ack, e_cpu_rdata);
            end
            advance();
        end
        drain_cpu();
        pix_pop = 1'b0;
    endtask

    task automatic test_random();
        frame_start = 1'b1;
        settle();
        advance();
        for (int i = 0; i < 1500; i++) begin
            pix_pop     = ($urandom % 4) != 0;
            frame_start = ($urandom % 400) == 0;
            rand_cpu(30);
            settle();
            n_vec++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata}) begin
                n_err++;
                $display("FAIL rand_mem%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i, mem_en, mem_we, mem_addr, mem_wdata,
                         e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata);
            end
            n_vec++;
            if ({pix_valid, pixel, underflow} !== {e_pix_valid, e_pixel, e_under}) begin
                n_err++;
                $display("FAIL rand_pix%0d: got v=%b px=%h uf=%b want %b/%h/%b", i, pix_valid, pixel, underflow,
                         e_pix_valid, e_pixel, e_under);
            end
            n_vec++;
            if ({cpu_ack, cpu_rdata} !== {e_ack, e_cpu_rdata}) begin
                n_err++;
                $display("FAIL rand_cpu%0d: got ack=%b rd=%h want %b/%h", i, cpu_ack, cpu_rdata, e_ack, e_cpu_rdata);
            end
            advance();
        end
        drain_cpu();
        pix_pop = 1'b0;
    endtask

    task automatic test_rst_mid();
        frame_start = 1'b1;
        settle();
        advance();
        for (int i = 0; i < 20; i++) begin
            pix_pop = (i > 10);
            settle();
            advance();
        end
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9; cpu_wdata = 32'h12345678;
        model_reset();
        settle();
        n_vec++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, pixel, pix_valid, underflow, cpu_ack, cpu_rdata} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got en=%b we=%b addr=%h wd=%h pix=%h v=%b uf=%b ack=%b rd=%h want all 0",
                     mem_en, mem_we, mem_addr, mem_wdata, pixel, pix_valid, underflow, cpu_ack, cpu_rdata);
        end
        advance();
        rst = 1'b0; cpu_req = 1'b0; pix_pop = 1'b0;
        settle();
        n_vec++;
        if (mem_en !== 1'b0 || pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle: got en=%b valid=%b want 0/0", mem_en, pix_valid);
        end
        advance();
    endtask

    initial begin
        for (int a = 0; a < MEMW; a++) begin
            ram[a]   = 32'(a);
            m_mem[a] = 32'(a);
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_underflow_pre_frame();
        test_prefill();
        test_stream();
        test_done();
        test_frame_restart();
        test_cpu_full();
        test_contention();
        test_random();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
